// File: rtl/breakout_ball.sv
// Breakout ball motion engine: serve/play/miss/game-over sequencing, wall and
// paddle bounces, block bounce requests, lives tracking and ball pixel-on.
module breakout_ball #(
  parameter int H_MAX      = 640,
  parameter int V_MAX      = 480,
  parameter int BALL_SIZE  = 8,
  parameter int SPEED      = 2,
  parameter int TICK_DIV   = 833333,
  parameter int LIVES      = 3,
  parameter int MISS_TICKS = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic [10:0] paddle_x_l,
  input  logic [10:0] paddle_x_r,
  input  logic [10:0] paddle_y_t,
  input  logic        launch,
  input  logic        moveU,
  input  logic        moveD,
  input  logic        moveL,
  input  logic        moveR,
  output logic [10:0] ball_x_l,
  output logic [10:0] ball_x_r,
  output logic [10:0] ball_y_t,
  output logic [10:0] ball_y_b,
  output logic        ball_ON,
  output logic [1:0]  lives,
  output logic        miss,
  output logic        game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW = (MISS_TICKS > 1) ? $clog2(MISS_TICKS + 1) : 1;

  localparam logic [10:0]   C_BS       = 11'(BALL_SIZE);
  localparam logic [10:0]   C_BS_M1    = 11'(BALL_SIZE - 1);
  localparam logic [10:0]   C_HALF     = 11'(BALL_SIZE / 2);
  localparam logic [10:0]   C_SPD      = 11'(SPEED);
  localparam logic [10:0]   C_XMAX     = 11'(H_MAX - BALL_SIZE);
  localparam logic [10:0]   C_YMAX     = 11'(V_MAX - BALL_SIZE);
  localparam logic [10:0]   C_X0       = 11'(H_MAX / 2 - BALL_SIZE / 2);
  localparam logic [10:0]   C_Y0       = 11'(V_MAX / 2);
  localparam logic [TW-1:0] C_TICK_END = TW'(TICK_DIV - 1);
  localparam logic [MW-1:0] C_MISS_END = MW'(MISS_TICKS - 1);
  localparam logic [1:0]    C_LIVES    = 2'(LIVES);

  localparam logic [1:0] S_SERVE = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_MISS  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  logic [1:0]    r_state;
  logic [10:0]   r_x, r_y;
  logic          r_dir_x, r_dir_y;
  logic [1:0]    r_lives;
  logic [TW-1:0] r_tick_cnt;
  logic [MW-1:0] r_miss_cnt;
  logic          r_miss, r_game_over, r_launch_d;

  logic          w_tick;
  logic [11:0]   w_pad_sum;
  logic [10:0]   w_pad_mid, w_mid_off, w_serve_x, w_serve_y;
  logic [10:0]   w_x_r, w_y_b;
  logic          w_dir_x, w_dir_y, w_paddle_hit, w_left_of_pad;
  logic [10:0]   w_x_nxt, w_y_nxt;
  logic          w_dx_nxt, w_dy_nxt, w_to_miss;

  assign w_tick        = (r_tick_cnt == C_TICK_END);
  assign w_pad_sum     = {1'b0, paddle_x_l} + {1'b0, paddle_x_r};
  assign w_pad_mid     = 11'(w_pad_sum >> 1);
  assign w_mid_off     = w_pad_mid - C_HALF;
  assign w_x_r         = r_x + C_BS_M1;
  assign w_y_b         = r_y + C_BS_M1;
  assign w_left_of_pad = (({1'b0, r_x} + {1'b0, C_HALF}) < {1'b0, w_pad_mid});
  assign w_paddle_hit  = (w_y_b < paddle_y_t) &&
                         (({1'b0, w_y_b} + {1'b0, C_SPD}) >= {1'b0, paddle_y_t}) &&
                         (w_x_r >= paddle_x_l) && (r_x <= paddle_x_r);

  // Ball resting on the paddle, centred and kept inside the playfield
  always_comb begin
    w_serve_x = C_X0;
    w_serve_y = C_Y0;
    if (w_pad_mid < C_HALF) begin
      w_serve_x = 11'd0;
    end else if (w_mid_off > C_XMAX) begin
      w_serve_x = C_XMAX;
    end else begin
      w_serve_x = w_mid_off;
    end
    if (paddle_y_t < C_BS) begin
      w_serve_y = 11'd0;
    end else begin
      w_serve_y = paddle_y_t - C_BS;
    end
  end

  // Block bounce requests; an opposing pair leaves that axis alone
  always_comb begin
    w_dir_x = r_dir_x;
    w_dir_y = r_dir_y;
    if (moveR && !moveL) begin
      w_dir_x = 1'b1;
    end else if (moveL && !moveR) begin
      w_dir_x = 1'b0;
    end else begin
      w_dir_x = r_dir_x;
    end
    if (moveU && !moveD) begin
      w_dir_y = 1'b0;
    end else if (moveD && !moveU) begin
      w_dir_y = 1'b1;
    end else begin
      w_dir_y = r_dir_y;
    end
  end

  // One motion step; a paddle hit steers x by which half of the paddle was struck
  always_comb begin
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_dx_nxt  = w_dir_x;
    w_dy_nxt  = w_dir_y;
    w_to_miss = 1'b0;
    if (!w_dir_x) begin
      if (r_x <= C_SPD) begin
        w_x_nxt  = 11'd0;
        w_dx_nxt = 1'b1;
      end else begin
        w_x_nxt  = r_x - C_SPD;
      end
    end else begin
      if (({1'b0, r_x} + {1'b0, C_SPD}) >= {1'b0, C_XMAX}) begin
        w_x_nxt  = C_XMAX;
        w_dx_nxt = 1'b0;
      end else begin
        w_x_nxt  = r_x + C_SPD;
      end
    end
    if (!w_dir_y) begin
      if (r_y <= C_SPD) begin
        w_y_nxt  = 11'd0;
        w_dy_nxt = 1'b1;
      end else begin
        w_y_nxt  = r_y - C_SPD;
      end
    end else if (w_paddle_hit) begin
      w_y_nxt  = w_serve_y;
      w_dy_nxt = 1'b0;
      w_dx_nxt = !w_left_of_pad;
    end else if (({1'b0, r_y} + {1'b0, C_SPD}) >= {1'b0, C_YMAX}) begin
      w_to_miss = 1'b1;
    end else begin
      w_y_nxt  = r_y + C_SPD;
    end
  end

  // Game sequencing and ball state
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_SERVE;
      r_x         <= C_X0;
      r_y         <= C_Y0;
      r_dir_x     <= 1'b1;
      r_dir_y     <= 1'b0;
      r_lives     <= C_LIVES;
      r_tick_cnt  <= '0;
      r_miss_cnt  <= '0;
      r_miss      <= 1'b0;
      r_game_over <= 1'b0;
      r_launch_d  <= 1'b0;
    end else begin
      r_launch_d <= launch;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_miss     <= 1'b0;
      case (r_state)
        S_SERVE: begin
          r_x     <= w_serve_x;
          r_y     <= w_serve_y;
          r_dir_x <= 1'b1;
          r_dir_y <= 1'b0;
          if (launch && !r_launch_d) r_state <= S_PLAY;
        end
        S_PLAY: begin
          r_dir_x <= w_dir_x;
          r_dir_y <= w_dir_y;
          if (w_tick) begin
            r_x     <= w_x_nxt;
            r_dir_x <= w_dx_nxt;
            if (w_to_miss) begin
              r_state    <= S_MISS;
              r_miss     <= 1'b1;
              r_lives    <= (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
              r_miss_cnt <= '0;
            end else begin
              r_y     <= w_y_nxt;
              r_dir_y <= w_dy_nxt;
            end
          end
        end
        S_MISS: begin
          if (w_tick) begin
            if (r_miss_cnt == C_MISS_END) begin
              r_state     <= (r_lives == 2'd0) ? S_OVER : S_SERVE;
              r_game_over <= (r_lives == 2'd0);
            end else begin
              r_miss_cnt <= r_miss_cnt + MW'(1);
            end
          end
        end
        S_OVER: begin
          r_game_over <= 1'b1;
        end
        default: begin
          r_state <= S_SERVE;
        end
      endcase
    end
  end

  // Pixel-on only while the ball is in play or waiting on the paddle
  always_comb begin
    ball_ON = 1'b0;
    if (((r_state == S_SERVE) || (r_state == S_PLAY)) &&
        (pix_x >= r_x) && (pix_x <= w_x_r) && (pix_y >= r_y) && (pix_y <= w_y_b)) begin
      ball_ON = 1'b1;
    end else begin
      ball_ON = 1'b0;
    end
  end

  assign ball_x_l  = r_x;
  assign ball_x_r  = w_x_r;
  assign ball_y_t  = r_y;
  assign ball_y_b  = w_y_b;
  assign lives     = r_lives;
  assign miss      = r_miss;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_breakout_ball.sv
// Self-checking bench for breakout_ball: opening vector table, hand-written
// wall/paddle/miss/game-over sequences, then randomized play against a model.
module tb_breakout_ball;
  localparam int HM = 640, VM = 480, BS = 8, SP = 2, TD = 4, LV = 3, MT = 3;
  localparam int XMX = HM - BS, YMX = VM - BS;

  logic        clk = 1'b0;
  logic        reset, launch, moveU, moveD, moveL, moveR;
  logic [10:0] pix_x, pix_y, paddle_x_l, paddle_x_r, paddle_y_t;
  logic [10:0] ball_x_l, ball_x_r, ball_y_t, ball_y_b;
  logic        ball_ON, miss, game_over;
  logic [1:0]  lives;
  int          n_checks = 0, n_errors = 0;

  breakout_ball #(.H_MAX(HM), .V_MAX(VM), .BALL_SIZE(BS), .SPEED(SP),
                  .TICK_DIV(TD), .LIVES(LV), .MISS_TICKS(MT)) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .paddle_x_l(paddle_x_l), .paddle_x_r(paddle_x_r), .paddle_y_t(paddle_y_t),
    .launch(launch), .moveU(moveU), .moveD(moveD), .moveL(moveL), .moveR(moveR),
    .ball_x_l(ball_x_l), .ball_x_r(ball_x_r), .ball_y_t(ball_y_t), .ball_y_b(ball_y_b),
    .ball_ON(ball_ON), .lives(lives), .miss(miss), .game_over(game_over));

  always #5 clk = ~clk;

  // Reference model: game state described directly by the rules
  typedef enum {M_SERVE, M_PLAY, M_MISS, M_OVER} mstate_t;
  mstate_t m_st;
  int m_x, m_y, m_dx, m_dy, m_lives, m_tick, m_mcnt, m_miss, m_go, m_ld;

  task automatic check(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_SERVE; m_x = HM/2 - BS/2; m_y = VM/2; m_dx = 1; m_dy = 0;
    m_lives = LV; m_tick = 0; m_mcnt = 0; m_miss = 0; m_go = 0; m_ld = 0;
  endtask

  task automatic model_step();
    int pl, pr, pt, ox, sx;
    bit tick;
    if (!reset) begin
      model_reset();
      return;
    end
    pl = int'(paddle_x_l); pr = int'(paddle_x_r); pt = int'(paddle_y_t);
    tick = (m_tick == TD - 1);
    m_tick = tick ? 0 : m_tick + 1;
    m_miss = 0;
    case (m_st)
      M_SERVE: begin
        sx = (pl + pr) / 2 - BS/2;
        m_x = (sx < 0) ? 0 : ((sx > XMX) ? XMX : sx);
        m_y = (pt < BS) ? 0 : pt - BS;
        m_dx = 1; m_dy = 0;
        if (launch && !m_ld) m_st = M_PLAY;
      end
      M_PLAY: begin
        if (moveR && !moveL) m_dx = 1; else if (moveL && !moveR) m_dx = 0;
        if (moveU && !moveD) m_dy = 0; else if (moveD && !moveU) m_dy = 1;
        if (tick) begin
          ox = m_x;
          if (m_dx == 0) begin
            if (ox <= SP) begin m_x = 0; m_dx = 1; end else m_x = ox - SP;
          end else begin
            if (ox + SP >= XMX) begin m_x = XMX; m_dx = 0; end else m_x = ox + SP;
          end
          if (m_dy == 0) begin
            if (m_y <= SP) begin m_y = 0; m_dy = 1; end else m_y = m_y - SP;
          end else if ((m_y + BS - 1 < pt) && (m_y + BS - 1 + SP >= pt) &&
                       (ox + BS - 1 >= pl) && (ox <= pr)) begin
            m_y = pt - BS; m_dy = 0;
            m_dx = (ox + BS/2 < (pl + pr) / 2) ? 0 : 1;
          end else if (m_y + SP >= YMX) begin
            m_st = M_MISS; m_miss = 1; m_mcnt = 0;
            if (m_lives > 0) m_lives = m_lives - 1;
          end else begin
            m_y = m_y + SP;
          end
        end
      end
      M_MISS: begin
        if (tick) begin
          if (m_mcnt + 1 == MT) begin
            if (m_lives == 0) begin m_st = M_OVER; m_go = 1; end else m_st = M_SERVE;
          end else m_mcnt = m_mcnt + 1;
        end
      end
      default: m_go = 1;
    endcase
    m_ld = launch;
  endtask

  task automatic compare_model();
    int on;
    on = ((m_st == M_SERVE || m_st == M_PLAY) && int'(pix_x) >= m_x && int'(pix_x) <= m_x + BS - 1 &&
          int'(pix_y) >= m_y && int'(pix_y) <= m_y + BS - 1) ? 1 : 0;
    check("mdl_x_l", ball_x_l, m_x);
    check("mdl_x_r", ball_x_r, m_x + BS - 1);
    check("mdl_y_t", ball_y_t, m_y);
    check("mdl_y_b", ball_y_b, m_y + BS - 1);
    check("mdl_ball_on", ball_ON, on);
    check("mdl_lives", lives, m_lives);
    check("mdl_miss", miss, m_miss);
    check("mdl_game_over", game_over, m_go);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic set_paddle(int l, int r, int t);
    paddle_x_l = 11'(l); paddle_x_r = 11'(r); paddle_y_t = 11'(t);
  endtask

  // Play until a miss, then check the pulse, the hidden period and what follows
  task automatic run_to_miss(int exp_lives, int exp_over);
    bit found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      pix_x = 11'(m_x + 3); pix_y = 11'(m_y + 3);
      cycle();
      if (miss === 1'b1) found = 1'b1;
    end
    check("miss_seen", found, 1);
    pix_x = 11'(m_x + 3); pix_y = 11'(m_y + 3);
    #1;
    check("miss_lives", lives, exp_lives);
    check("miss_hidden", ball_ON, 0);
    cycle();
    check("miss_one_cycle", miss, 0);
    for (int j = 0; j < 10; j++) begin
      cycle();
      check("miss_hidden_hold", ball_ON, 0);
    end
    cycle();
    if (exp_over != 0) begin
      check("over_flag", game_over, 1);
      check("over_hidden", ball_ON, 0);
    end else begin
      cycle();
      check("reserve_x", ball_x_l, XMX);
      check("reserve_y", ball_y_t, 432);
      check("reserve_go", game_over, 0);
    end
  endtask

  typedef struct { int rst; int lau; int ml; int mr; int ex; int ey; } vec_t;
  vec_t vt[22];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int xh;
    bit ok;
    vt[0]  = '{0,0,0,0,316,240}; vt[1]  = '{0,0,0,0,316,240};
    vt[2]  = '{1,0,0,0,335,432}; vt[3]  = '{1,1,0,0,335,432};
    vt[4]  = '{1,1,0,0,335,432}; vt[5]  = '{1,0,0,0,337,430};
    vt[6]  = '{1,0,0,0,337,430}; vt[7]  = '{1,0,0,0,337,430};
    vt[8]  = '{1,0,0,0,337,430}; vt[9]  = '{1,0,0,0,339,428};
    vt[10] = '{1,0,1,0,339,428}; vt[11] = '{1,0,1,0,339,428};
    vt[12] = '{1,0,1,0,339,428}; vt[13] = '{1,0,0,0,337,426};
    vt[14] = '{1,0,1,1,337,426}; vt[15] = '{1,0,1,1,337,426};
    vt[16] = '{1,0,1,1,337,426}; vt[17] = '{1,0,1,1,335,424};
    vt[18] = '{1,0,1,0,335,424}; vt[19] = '{1,0,1,0,335,424};
    vt[20] = '{1,0,1,0,335,424}; vt[21] = '{1,0,1,0,333,422};

    reset = 1'b0; launch = 1'b0; moveU = 1'b0; moveD = 1'b0; moveL = 1'b0; moveR = 1'b0;
    pix_x = 11'd0; pix_y = 11'd0;
    set_paddle(300, 379, 440);
    model_reset();

    // Opening vectors: reset, serve on paddle, launch, held and opposing requests
    for (int i = 0; i < 22; i++) begin
      reset = (vt[i].rst != 0); launch = (vt[i].lau != 0);
      moveL = (vt[i].ml != 0);  moveR = (vt[i].mr != 0);
      cycle();
      check($sformatf("tbl_x[%0d]", i), ball_x_l, vt[i].ex);
      check($sformatf("tbl_y[%0d]", i), ball_y_t, vt[i].ey);
      check($sformatf("tbl_lives[%0d]", i), lives, 3);
      check($sformatf("tbl_go[%0d]", i), game_over, 0);
    end
    moveL = 1'b0; moveR = 1'b0;

    // Top wall: y=2 then the next tick clamps to 0 and turns downward
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      cycle();
      if (m_y == 2) ok = 1'b1;
    end
    check("top_reach", ok, 1);
    repeat (4) cycle();
    check("top_wall_y0", ball_y_t, 0);
    repeat (4) cycle();
    check("top_wall_y2", ball_y_t, 2);

    // Paddle hit: ball centre left of paddle centre sends it left and up
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      cycle();
      if (m_y == 432 && m_dy == 1 && m_st == M_PLAY) ok = 1'b1;
    end
    check("pad_reach", ok, 1);
    set_paddle(m_x, m_x + 40, 440);
    repeat (4) cycle();
    check("pad_hit_y", ball_y_t, 432);
    xh = m_x;
    repeat (4) cycle();
    check("pad_up_y", ball_y_t, 430);
    check("pad_left_x", ball_x_l, (xh <= SP) ? 0 : xh - SP);

    // Misses with the paddle parked off-screen, down to game over
    set_paddle(2000, 2040, 440);
    run_to_miss(2, 0);
    launch = 1'b1; cycle(); launch = 1'b0; cycle();
    run_to_miss(1, 0);
    launch = 1'b1; cycle(); launch = 1'b0; cycle();
    run_to_miss(0, 1);
    for (int j = 0; j < 8; j++) begin
      launch = j[0];
      cycle();
      check("over_hold", game_over, 1);
      check("over_lives", lives, 0);
    end
    launch = 1'b0;
    set_paddle(300, 379, 440);
    reset = 1'b0; cycle();
    check("rst_go", game_over, 0);
    check("rst_lives", lives, 3);
    check("rst_x", ball_x_l, 316);
    check("rst_y", ball_y_t, 240);
    reset = 1'b1; cycle();
    check("rst_serve_x", ball_x_l, 335);
    check("rst_serve_y", ball_y_t, 432);

    // Randomized play against the model
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(0, 399) != 0);
      launch = ($urandom_range(0, 7) == 0);
      moveU  = ($urandom_range(0, 3) == 0);
      moveD  = ($urandom_range(0, 3) == 0);
      moveL  = ($urandom_range(0, 3) == 0);
      moveR  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        xh = $urandom_range(0, 560);
        set_paddle(xh, xh + $urandom_range(20, 80), $urandom_range(420, 470));
      end
      if ($urandom_range(0, 1) == 0) begin
        pix_x = 11'(m_x + $urandom_range(0, 9) - 1);
        pix_y = 11'(m_y + $urandom_range(0, 9) - 1);
      end else begin
        pix_x = 11'($urandom_range(0, HM - 1));
        pix_y = 11'($urandom_range(0, VM - 1));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
